// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes that need special flag handling,
// flag bit positions, and the flag-class decoder used by writeback.
package alu_pkg;

   // Multiply/divide opcodes update Z/N only; V and C keep their value
   localparam logic [3:0] OP_MUL  = 4'b1001;
   localparam logic [3:0] OP_DIVQ = 4'b1011;
   localparam logic [3:0] OP_DIVR = 4'b1101;

   // Bit positions inside the 4-bit flag vector {Z, N, V, C}
   localparam int F_Z = 3;
   localparam int F_N = 2;
   localparam int F_V = 1;
   localparam int F_C = 0;

   typedef enum logic [1:0] {
      FC_ARITH,   // Z/N from result, V/C from ALU
      FC_LOGIC,   // Z/N from result, V/C cleared
      FC_MULDIV   // Z/N from result, V/C hold
   } flag_class_e;

   function automatic flag_class_e op_class(input logic [3:0] sel);
      if (!sel[3]) begin
         return FC_ARITH;
      end else if (sel == OP_MUL || sel == OP_DIVQ || sel == OP_DIVR) begin
         return FC_MULDIV;
      end else begin
         return FC_LOGIC;
      end
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the
// output; the skid entry catches one item while the main entry is stalled,
// so in_ready depends only on register state.
module skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid;
   logic         skid_valid;
   logic [W-1:0] main_data;
   logic [W-1:0] skid_data;
   logic         drain;
   logic         take;

   // The skid entry only ever fills behind a full main entry, so while it is
   // occupied no new item can arrive.
   assign drain = main_valid & out_ready;
   assign take  = in_valid & ~skid_valid & ~flush;

   // Entry state: fill main first, overflow to skid, refill main from skid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: payload registers are reset too, because out_data must read 0 out of reset.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (drain) begin
            // NOTE: non-blocking, so the copy sees the pre-edge skid contents.
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end
      end else if (take) begin
         if (!main_valid || drain) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
      end else if (drain) begin
         main_valid <= 1'b0;
      end
   end

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: rtl/alu_wb_stage.sv
// Registered stage after the ALU: keeps the architectural Z/N/V/C flags
// and forwards {rd, result} to register-file writeback through a skid buffer.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int BW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] alu_dout,
   input  logic          alu_v,
   input  logic          alu_c,
   input  logic [3:0]    alu_sel,
   input  logic [RW-1:0] in_rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_data,
   output logic [RW-1:0] out_rd,
   output logic          flag_z,
   output logic          flag_n,
   output logic          flag_v,
   output logic          flag_c
);

   logic [3:0]       flags;
   logic [3:0]       flags_next;
   logic             accept;
   logic [RW+BW-1:0] wb_payload;

   // Ops offered during a flush are dropped, so they must not touch flags
   assign accept = in_valid & in_ready & ~flush;

   // Next flag value for the op currently offered by the ALU
   always_comb begin
      // NOTE: defaulting to the current value first keeps this block latch-free.
      flags_next      = flags;
      flags_next[F_Z] = (alu_dout == '0);
      flags_next[F_N] = alu_dout[BW-1];
      case (op_class(alu_sel))
         FC_ARITH: begin
            flags_next[F_V] = alu_v;
            flags_next[F_C] = alu_c;
         end
         FC_LOGIC: begin
            flags_next[F_V] = 1'b0;
            flags_next[F_C] = 1'b0;
         end
         default: ;
      endcase
   end

   // Flags follow program order on the accept edge, regardless of writeback stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (accept) begin
         flags <= flags_next;
      end
   end

   assign flag_z = flags[F_Z];
   assign flag_n = flags[F_N];
   assign flag_v = flags[F_V];
   assign flag_c = flags[F_C];

   skid_buf #(
      .W(RW + BW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_rd, alu_dout}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (wb_payload)
   );

   assign out_data = wb_payload[BW-1:0];
   assign out_rd   = wb_payload[RW+BW-1:BW];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Testbench for alu_wb_stage: directed scenarios plus randomized traffic,
// with a scoreboard queue of expected writebacks and a flag reference model.
module tb_alu_wb_stage;

   localparam int BW = 16;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] alu_dout;
   logic          alu_v;
   logic          alu_c;
   logic [3:0]    alu_sel;
   logic [RW-1:0] in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic [RW-1:0] out_rd;
   logic          flag_z;
   logic          flag_n;
   logic          flag_v;
   logic          flag_c;

   typedef struct {
      logic [RW-1:0] rd;
      logic [BW-1:0] data;
   } wb_t;

   wb_t        exp_q[$];
   logic [3:0] model_f;
   int         checks = 0;
   int         errors = 0;
   bit         rand_mode = 0;

   alu_wb_stage #(.BW(BW), .RW(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_dout  (alu_dout),
      .alu_v     (alu_v),
      .alu_c     (alu_c),
      .alu_sel   (alu_sel),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_v    (flag_v),
      .flag_c    (flag_c)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference flag rule written from the architectural definition
   function automatic logic [3:0] ref_flags(input logic [3:0] old, input logic [15:0] d,
                                            input logic [3:0] sel, input logic v, input logic c);
      logic z, n, nv, nc;
      z  = (d == 0);
      n  = (d >= 16'h8000);
      nv = old[1];
      nc = old[0];
      if (sel < 8) begin
         nv = v;
         nc = c;
      end else if (!(sel == 9 || sel == 11 || sel == 13)) begin
         nv = 0;
         nc = 0;
      end
      return {z, n, nv, nc};
   endfunction

   function automatic logic [3:0] dut_flags();
      return {flag_z, flag_n, flag_v, flag_c};
   endfunction

   // Offer one op; it stays offered until accepted (bounded)
   task automatic send(input logic [2:0] rd, input logic [15:0] d, input logic [3:0] sel,
                       input logic v, input logic c);
      bit ok = 0;
      in_valid = 1; in_rd = rd; alu_dout = d; alu_sel = sel; alu_v = v; alu_c = c;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (in_ready && !flush) begin
            exp_q.push_back('{rd: rd, data: d});
            model_f = ref_flags(model_f, d, sel, v, c);
            ok = 1;
         end
         @(posedge clk);
         #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 0;
      if (!ok) check("send_timeout", 0, 1);
      else check("flags", {28'd0, dut_flags()}, {28'd0, model_f});
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit done = 0;
      out_ready = 1;
      for (int n = 0; n < 50 && !done; n++) begin
         cycle();
         done = (exp_q.size() == 0) && !out_valid;
      end
      check("drain_empty", {31'd0, done}, 1);
   endtask

   // Monitor: pops the scoreboard on every completed writeback and checks hold stability
   bit            prev_stall = 0;
   logic [BW-1:0] prev_data;
   logic [RW-1:0] prev_rd;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && out_valid) begin
            check("hold_data", {16'd0, out_data}, {16'd0, prev_data});
            check("hold_rd", {29'd0, out_rd}, {29'd0, prev_rd});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wb", 1, 0);
            end else begin
               wb_t e;
               e = exp_q.pop_front();
               check("wb_data", {16'd0, out_data}, {16'd0, e.data});
               check("wb_rd", {29'd0, out_rd}, {29'd0, e.rd});
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         prev_data  = out_data;
         prev_rd    = out_rd;
      end
   end

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
      alu_dout = 0; alu_v = 0; alu_c = 0; alu_sel = 0; in_rd = 0;
      model_f = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      check("rst_flags", {28'd0, dut_flags()}, 0);
      check("rst_out_data", {16'd0, out_data}, 0);
      check("rst_out_rd", {29'd0, out_rd}, 0);
      @(negedge clk);
      rst_n = 1;
      cycle();

      // First op: visible one cycle after accept
      out_ready = 1;
      send(3'd2, 16'h0000, 4'b0000, 1'b0, 1'b1);
      check("t1_out_valid", {31'd0, out_valid}, 1);
      check("t1_out_data", {16'd0, out_data}, 0);
      check("t1_out_rd", {29'd0, out_rd}, 2);
      check("t1_flags", {28'd0, dut_flags()}, 4'b1001);
      drain();

      // Flag classes
      send(3'd1, 16'h1234, 4'b0000, 1'b1, 1'b1);
      check("t3_add", {28'd0, dut_flags()}, 4'b0011);
      send(3'd1, 16'h8000, 4'b1000, 1'b1, 1'b1);
      check("t3_and", {28'd0, dut_flags()}, 4'b0100);
      send(3'd1, 16'h0000, 4'b0000, 1'b1, 1'b1);
      send(3'd1, 16'h0000, 4'b1001, 1'b0, 1'b0);
      check("t3_mul_hold", {28'd0, dut_flags()}, 4'b1011);
      drain();

      // Back-pressure: A in main, B in skid, C held
      out_ready = 0;
      send(3'd3, 16'hAAAA, 4'b0001, 1'b0, 1'b0);
      check("t2_in_ready_a", {31'd0, in_ready}, 1);
      send(3'd4, 16'hBBBB, 4'b0001, 1'b0, 1'b0);
      check("t2_in_ready_b", {31'd0, in_ready}, 0);
      check("t2_main_a", {16'd0, out_data}, 16'hAAAA);
      in_valid = 1; in_rd = 3'd5; alu_dout = 16'hCCCC; alu_sel = 4'b0001;
      repeat (2) begin
         @(negedge clk);
         check("t2_c_held", {31'd0, in_ready}, 0);
         cycle();
      end
      out_ready = 1;
      send(3'd5, 16'hCCCC, 4'b0001, 1'b0, 1'b0);
      drain();

      // Accept and drain on the same edge with main full
      send(3'd6, 16'h0101, 4'b0010, 1'b0, 1'b0);
      send(3'd7, 16'h0202, 4'b0010, 1'b0, 1'b0);
      check("t4_main_new", {16'd0, out_data}, 16'h0202);
      check("t4_in_ready", {31'd0, in_ready}, 1);
      cycle();
      check("t4_skid_empty", {31'd0, out_valid}, 0);
      drain();

      // Flush with both entries buffered plus an offered op
      out_ready = 0;
      send(3'd1, 16'h1111, 4'b0000, 1'b0, 1'b0);
      send(3'd2, 16'h2222, 4'b0000, 1'b0, 1'b0);
      flush = 1; in_valid = 1; alu_dout = 16'h0000; alu_sel = 4'b0000; alu_v = 1; alu_c = 1;
      cycle();
      flush = 0; in_valid = 0;
      exp_q.delete();
      check("t5_out_valid", {31'd0, out_valid}, 0);
      check("t5_in_ready", {31'd0, in_ready}, 1);
      check("t5_flags", {28'd0, dut_flags()}, {28'd0, model_f});

      // Flush with room free: the offered op must still be ignored
      send(3'd3, 16'h3333, 4'b0000, 1'b0, 1'b0);
      flush = 1; in_valid = 1; alu_dout = 16'h0000; alu_sel = 4'b0000; alu_v = 1; alu_c = 1;
      cycle();
      flush = 0; in_valid = 0;
      exp_q.delete();
      check("t5b_out_valid", {31'd0, out_valid}, 0);
      check("t5b_flags", {28'd0, dut_flags()}, {28'd0, model_f});
      cycle();
      check("t5b_not_accepted", {31'd0, out_valid}, 0);
      drain();

      // Randomized traffic with random back-pressure
      rand_mode = 1;
      for (int i = 0; i < 300; i++) begin
         logic [15:0] d;
         case ($urandom_range(0, 3))
            0: d = 16'h0000;
            1: d = 16'h8000 | 16'($urandom);
            default: d = 16'($urandom);
         endcase
         repeat ($urandom_range(0, 2)) begin
            cycle();
            out_ready = ($urandom_range(0, 3) != 0);
         end
         send(3'($urandom), d, 4'($urandom), 1'($urandom), 1'($urandom));
      end
      rand_mode = 0;
      drain();

      // Async reset while both entries are full
      out_ready = 0;
      send(3'd1, 16'h4444, 4'b0000, 1'b1, 1'b1);
      send(3'd2, 16'h5555, 4'b0000, 1'b1, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      check("t6_out_valid", {31'd0, out_valid}, 0);
      check("t6_in_ready", {31'd0, in_ready}, 1);
      check("t6_flags", {28'd0, dut_flags()}, 0);
      check("t6_out_data", {16'd0, out_data}, 0);
      exp_q.delete();
      model_f = 0;
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1;
      cycle();
      check("t6_after_release", {31'd0, out_valid}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
